// File: rtl/seq_normalizer_8_pkg.sv
// Shared types for the multi-cycle normalizer.
// State encoding, direction constants and shift-count width helper.
package seq_normalizer_8_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic DIR_LEFT  = 1'b0;
   localparam logic DIR_RIGHT = 1'b1;

   function automatic int shw_of(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/seq_normalizer_8.sv
// Multi-cycle normalizer: shifts one bit per cycle until the leading
// (left) or trailing (right) bit is set; reports shift count and zero flag.
module seq_normalizer_8
   import seq_normalizer_8_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int SHW   = shw_of(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [SHW-1:0]   out_shamt,
   output logic             out_zero
);

   state_t           state, state_n;
   logic [WIDTH-1:0] work, work_n;
   logic [SHW-1:0]   count, count_n;
   logic             dir, dir_n;
   logic [WIDTH-1:0] data_n;
   logic [SHW-1:0]   shamt_n;
   logic             zero_n;
   logic             stop;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign stop      = (dir == DIR_RIGHT) ? work[0] : work[WIDTH-1];

   always_comb begin
      state_n = state;
      work_n  = work;
      count_n = count;
      dir_n   = dir;
      data_n  = out_data;
      shamt_n = out_shamt;
      zero_n  = out_zero;
      unique case (state)
         IDLE: begin
            if (in_valid) begin
               work_n  = in_data;
               dir_n   = in_dir;
               count_n = '0;
               if (in_data == '0) begin
                  state_n = DONE;
                  data_n  = '0;
                  shamt_n = '0;
                  zero_n  = 1'b1;
               end else begin
                  state_n = SHIFT;
               end
            end
         end
         SHIFT: begin
            // Results are published only on the transition into DONE.
            if (stop) begin
               state_n = DONE;
               data_n  = work;
               shamt_n = count;
               zero_n  = 1'b0;
            end else begin
               work_n  = (dir == DIR_RIGHT) ? (work >> 1) : (work << 1);
               count_n = count + 1'b1;
            end
         end
         DONE: begin
            if (out_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         work      <= '0;
         count     <= '0;
         dir       <= DIR_LEFT;
         out_data  <= '0;
         out_shamt <= '0;
         out_zero  <= 1'b0;
      end else begin
         state     <= state_n;
         work      <= work_n;
         count     <= count_n;
         dir       <= dir_n;
         out_data  <= data_n;
         out_shamt <= shamt_n;
         out_zero  <= zero_n;
      end
   end

   // A nonzero word must hit its stop bit before the count reaches WIDTH-1.
   a_count_bound : assert property (
      @(posedge clk) disable iff (rst)
      (state == SHIFT && !stop) |-> (int'(count) < WIDTH - 1)
   );

endmodule

// File: tb/tb_seq_normalizer_8.sv
// Directed-vector and exhaustive-sweep bench for seq_normalizer_8.
// Table rows cover single words; hand sequences cover backpressure and reset.
module tb_seq_normalizer_8;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_dir;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_shamt;
   logic       out_zero;

   int checks;
   int failures;

   seq_normalizer_8 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_shamt (out_shamt),
      .out_zero  (out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       dir;
      logic [7:0] data;
      logic [7:0] exp_data;
      logic [2:0] exp_shamt;
      logic       exp_zero;
      int         exp_lat;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Offer one word, wait (bounded) for out_valid; lat = edges after accept.
   task automatic send(input logic d, input logic [7:0] w,
                       output logic [7:0] od, output logic [2:0] os,
                       output logic oz, output int lat);
      @(negedge clk);
      chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_dir   = d;
      in_data  = w;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'hA5;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
      od = out_data;
      os = out_shamt;
      oz = out_zero;
   endtask

   // With out_ready high the result must vanish after exactly one cycle.
   task automatic after_hs();
      @(posedge clk);
      #1;
      chk("valid_one_cycle", {31'd0, out_valid}, 32'd0);
      chk("ready_after_hs", {31'd0, in_ready}, 32'd1);
   endtask

   function automatic int ref_count(input logic d, input logic [7:0] w);
      int  n;
      bit  hit;
      n   = 0;
      hit = 0;
      for (int i = 0; i < 8; i++) begin
         if (!hit) begin
            if ((d == 1'b0) ? w[7-i] : w[i]) hit = 1;
            else n++;
         end
      end
      return (n == 8) ? 0 : n;
   endfunction

   initial begin
      logic [7:0] od;
      logic [2:0] os;
      logic       oz;
      int         lat;
      int         k;
      logic [7:0] ed;
      bit         seen;

      checks   = 0;
      failures = 0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_dir   = 1'b0;
      out_ready = 1'b1;

      vecs[0] = '{1'b0, 8'h13, 8'h98, 3'd3, 1'b0, 4};
      vecs[1] = '{1'b1, 8'hB0, 8'h0B, 3'd4, 1'b0, 5};
      vecs[2] = '{1'b0, 8'h80, 8'h80, 3'd0, 1'b0, 1};
      vecs[3] = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 0};
      vecs[4] = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b1, 0};
      vecs[5] = '{1'b1, 8'h01, 8'h01, 3'd0, 1'b0, 1};
      vecs[6] = '{1'b1, 8'h80, 8'h01, 3'd7, 1'b0, 8};
      vecs[7] = '{1'b0, 8'h01, 8'h80, 3'd7, 1'b0, 8};
      vecs[8] = '{1'b0, 8'h0F, 8'hF0, 3'd4, 1'b0, 5};
      vecs[9] = '{1'b1, 8'h06, 8'h03, 3'd1, 1'b0, 2};

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset_out_data", {24'd0, out_data}, 32'd0);
      chk("reset_out_shamt", {29'd0, out_shamt}, 32'd0);
      chk("reset_out_zero", {31'd0, out_zero}, 32'd0);

      for (int i = 0; i < 10; i++) begin
         send(vecs[i].dir, vecs[i].data, od, os, oz, lat);
         chk($sformatf("vec%0d_data", i), {24'd0, od}, {24'd0, vecs[i].exp_data});
         chk($sformatf("vec%0d_shamt", i), {29'd0, os}, {29'd0, vecs[i].exp_shamt});
         chk($sformatf("vec%0d_zero", i), {31'd0, oz}, {31'd0, vecs[i].exp_zero});
         if (vecs[i].exp_zero)
            chk($sformatf("vec%0d_lat_le1", i), {31'd0, lat <= 1}, 32'd1);
         else
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
         after_hs();
      end

      // Backpressure: result held, new input ignored, single handshake.
      out_ready = 1'b0;
      send(1'b0, 8'h01, od, os, oz, lat);
      chk("bp_lat", lat, 32'd8);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h55;
      in_dir   = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         chk("bp_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_data", {24'd0, out_data}, 32'h80);
         chk("bp_shamt", {29'd0, out_shamt}, 32'd7);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      after_hs();
      seen = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1;
      end
      chk("bp_no_extra_result", {31'd0, seen}, 32'd0);

      // Reset in flight: no stale result, then normal operation.
      @(negedge clk);
      in_valid = 1'b1;
      in_dir   = 1'b0;
      in_data  = 8'h01;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_mid_data", {24'd0, out_data}, 32'd0);
      seen = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1;
      end
      chk("rst_mid_no_stale", {31'd0, seen}, 32'd0);
      send(1'b0, 8'h40, od, os, oz, lat);
      chk("post_rst_shamt", {29'd0, os}, 32'd1);
      chk("post_rst_data", {24'd0, od}, 32'h80);
      after_hs();

      // Exhaustive sweep against a reference zero-count model.
      for (int d = 0; d < 2; d++) begin
         for (int v = 0; v < 256; v++) begin
            send(d[0], v[7:0], od, os, oz, lat);
            k = ref_count(d[0], v[7:0]);
            ed = (d == 0) ? (v[7:0] << k) : (v[7:0] >> k);
            chk($sformatf("sw_d%0d_%02h_data", d, v), {24'd0, od}, {24'd0, ed});
            chk($sformatf("sw_d%0d_%02h_shamt", d, v), {29'd0, os}, k);
            chk($sformatf("sw_d%0d_%02h_zero", d, v), {31'd0, oz},
                {31'd0, v == 0});
            if (v != 0) begin
               if (d == 0)
                  chk($sformatf("sw_d%0d_%02h_inv", d, v),
                      {31'd0, ((od >> os) == v[7:0]) && od[7]}, 32'd1);
               else
                  chk($sformatf("sw_d%0d_%02h_inv", d, v),
                      {31'd0, ((od << os) == v[7:0]) && od[0]}, 32'd1);
            end
            @(posedge clk);
            #1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
